// File: rtl/evenodd_pkg.sv
// ---------------------------------------------------------------------------
// evenodd_pkg
// Shared definitions for the even/odd parity path: the generator FSM state
// type, the per-word increment and the parity encoding that the downstream
// classifier also uses.
// ---------------------------------------------------------------------------
package evenodd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Adding 2 keeps the LSB, so a burst never changes parity, even on wrap.
    localparam int unsigned STEP = 2;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/evenodd_step_ctr.sv
// ---------------------------------------------------------------------------
// evenodd_step_ctr
// Holds the current burst word and the number of words still to emit.
//   clk, reset   : clock, asynchronous active-low reset
//   load         : capture load_value / load_count (start of a burst)
//   advance      : one word consumed: value += STEP, remaining -= 1
//   load_value   : first word of the burst (parity already applied)
//   load_count   : burst length, must be non-zero when load is used
//   value        : current word
//   last         : current word is the final one (remaining == 1)
// ---------------------------------------------------------------------------
module evenodd_step_ctr
    import evenodd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] load_value,
    input  logic [CNT_W-1:0] load_count,
    output logic [WIDTH-1:0] value,
    output logic             last
);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value     <= '0;
            remaining <= '0;
        end else if (load) begin
            value     <= load_value;
            remaining <= load_count;
        end else if (advance) begin
            value     <= value + WIDTH'(STEP);
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/evenodd_seq_gen.sv
// ---------------------------------------------------------------------------
// evenodd_seq_gen
// Command-driven generator: emits a burst of cmd_count words of one parity
// (all even or all odd), starting from cmd_start with its LSB forced to
// cmd_odd, stepping by 2 per accepted word, over a valid/ready output.
//   clk, reset            : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready : command handshake
//   cmd_odd               : requested parity (1 = odd, 0 = even)
//   cmd_start             : seed word (LSB replaced by cmd_odd)
//   cmd_count             : words to emit (0 = no words, straight to done)
//   out_valid / out_ready : output handshake
//   data_out              : generated word
//   out_last              : current word ends the burst
//   busy                  : burst in progress (GEN or DONE)
//   done                  : one-cycle pulse at burst completion
//   err_inj               : only with EVENODD_ERR_INJ_EN defined; when high
//                           at a handshake, the next word has its LSB flipped
// ---------------------------------------------------------------------------
module evenodd_seq_gen
    import evenodd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_odd,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [CNT_W-1:0] cmd_count,
`ifdef EVENODD_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic             load, advance;
    logic [WIDTH-1:0] value;
    logic             last;
    logic             err_flag;
    logic             unused_seed_lsb;

    // The seed LSB is replaced by the requested parity.
    assign unused_seed_lsb = cmd_start[0];

    assign load    = (state == IDLE) && cmd_valid && (cmd_count != '0);
    assign advance = (state == GEN) && out_ready;

    evenodd_step_ctr #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .advance    (advance),
        .load_value ({cmd_start[WIDTH-1:1], cmd_odd}),
        .load_count (cmd_count),
        .value      (value),
        .last       (last)
    );

`ifdef EVENODD_ERR_INJ_EN
    // Flip only the emitted copy; the counter sequence stays untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_flag <= 1'b0;
        end else if (load) begin
            err_flag <= 1'b0;
        end else if (advance) begin
            err_flag <= err_inj;
        end
    end
`else
    assign err_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        data_out  = '0;
        case (state)
            IDLE: begin
                // Gated by reset so cmd_ready reads 0 while held in reset.
                cmd_ready = reset;
                if (cmd_valid) begin
                    state_nxt = (cmd_count != '0) ? GEN : DONE;
                end
            end
            GEN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = last;
                data_out  = {value[WIDTH-1:1], value[0] ^ err_flag};
                if (out_ready && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
